// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes and an operand-B accumulator.
// Define LOGIC_UNIT_FLAGS_EN to add the out_zero / out_parity result flags.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_use_acc,
    input  logic             in_acc_wr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] acc_q
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_parity
`endif
);

    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~a;
            3'b100:  r = ~(a | b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = ~b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

    logic             vld_p1, vld_p2;
    logic [WIDTH-1:0] y_p1, y_p2;
    logic [WIDTH-1:0] acc_r;
    logic             in_acc, out_acc, adv_p1;
    logic [WIDTH-1:0] b_p0, res_p0;

    assign in_ready = !vld_p1 || !vld_p2 || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = vld_p2 && out_ready;
    // S1 drains whenever S2 is free or is being emptied this cycle
    assign adv_p1   = vld_p1 && (!vld_p2 || out_ready);

    // Stage 0: operand select and combinational result
    assign b_p0   = in_use_acc ? acc_r : in_b;
    assign res_p0 = logic_op(in_op, in_a, b_p0);

    // Stage 1 / stage 2 control, output register and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            y_p2   <= '0;
            acc_r  <= '0;
        end else begin
            if (in_acc)
                vld_p1 <= 1'b1;
            else if (adv_p1)
                vld_p1 <= 1'b0;

            if (adv_p1)
                vld_p2 <= 1'b1;
            else if (out_acc)
                vld_p2 <= 1'b0;

            if (adv_p1)
                y_p2 <= y_p1;

            if (in_acc && in_acc_wr)
                acc_r <= res_p0;
        end
    end

    // Stage 1 data register
    always_ff @(posedge clk) begin
        if (in_acc)
            y_p1 <= res_p0;
    end

    assign out_valid = vld_p2;
    assign out_y     = y_p2;
    assign acc_q     = acc_r;

`ifdef LOGIC_UNIT_FLAGS_EN
    logic zero_p1, parity_p1, zero_p2, parity_p2;

    always_ff @(posedge clk) begin
        if (in_acc) begin
            zero_p1   <= (res_p0 == '0);
            parity_p1 <= ^res_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_p2   <= 1'b0;
            parity_p2 <= 1'b0;
        end else if (adv_p1) begin
            zero_p2   <= zero_p1;
            parity_p2 <= parity_p1;
        end
    end

    assign out_zero   = zero_p2;
    assign out_parity = parity_p2;
`endif

endmodule
